// File: rtl/modexp_pkg.sv
// Shared types for the sequential modular exponentiator: FSM states, multiplier
// operand selection and the closed-form transaction latency.
package modexp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_SQR,
        ST_MUL,
        ST_FIN
    } state_t;

    typedef enum logic [1:0] {
        OP_REDUCE,
        OP_SQUARE,
        OP_MULTIPLY
    } mm_op_t;

    // Cycles from the accept cycle (cycle 0) to the done cycle.
    function automatic int modexp_latency(input int nw, input int ew,
                                          input logic [63:0] e, input logic n_zero);
        int  z;
        int  r;
        int  p;
        logic found;
        z = 0;
        r = 0;
        p = 0;
        found = 1'b0;
        if (n_zero) begin
            return 2;
        end
        for (int i = ew - 1; i >= 0; i--) begin
            if (!found) begin
                if (e[i]) begin
                    found = 1'b1;
                end else begin
                    z++;
                end
            end else begin
                r++;
                if (e[i]) begin
                    p++;
                end
            end
        end
        if (!found) begin
            return 1 + (nw + 1) + ew + 1;
        end
        return 1 + (nw + 1) + (z + 1) + (nw + 1) * (r + p) + 1;
    endfunction

endpackage

// File: rtl/modexp_seq_if.sv
// Start/done handshake bundle between the operand loader and the exponentiator.
interface modexp_seq_if #(
    parameter int N = 32,
    parameter int E = N
);
    logic         start;
    logic [N-1:0] m;
    logic [E-1:0] e;
    logic [N-1:0] n;
    logic         ready;
    logic         done;
    logic         err;
    logic [N-1:0] o;

    modport master (output start, m, e, n, input ready, done, err, o);
    modport slave  (input start, m, e, n, output ready, done, err, o);
endinterface

// File: rtl/modmult_seq.sv
// Bit-serial Blakley modular multiplier: o = x*y mod n in one load cycle plus
// N iterations, MSB-first over x. Requires y < n or y == 1.
module modmult_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic [N-1:0] n,
    output logic [N-1:0] o,
    output logic         done
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  x_q;
    logic [N-1:0]  y_q;
    logic [N-1:0]  n_q;
    logic [N+1:0]  p_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;

    logic [N+1:0]  n_ext;
    logic [N+1:0]  sum;
    logic [N+1:0]  red1;
    logic [N+1:0]  p_d;

    // 2p + y < 3n, so two conditional subtractions always land below n.
    always_comb begin
        n_ext = {2'b00, n_q};
        sum   = (p_q << 1) + (x_q[N-1] ? {2'b00, y_q} : '0);
        red1  = (sum >= n_ext) ? (sum - n_ext) : sum;
        p_d   = (red1 >= n_ext) ? (red1 - n_ext) : red1;
    end

    assign o    = p_d[N-1:0];
    assign done = run_q && (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            n_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            x_q   <= x;
            y_q   <= y;
            n_q   <= n;
            p_q   <= '0;
            cnt_q <= CW'(N);
            run_q <= 1'b1;
        end else if (run_q) begin
            x_q   <= x_q << 1;
            p_q   <= p_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/modexp_seq.sv
// Left-to-right square-and-multiply modular exponentiator sharing one
// bit-serial multiplier across reduce, square and multiply steps.
module modexp_seq
    import modexp_pkg::*;
#(
    parameter int N = 32,
    parameter int E = N
) (
    input  logic         clk,
    input  logic         rst,
    modexp_seq_if.slave  bus
);
    localparam int CW = $clog2(E + 1);

    state_t        state_q, state_d;
    logic [N-1:0]  m_q, m_d;
    logic [N-1:0]  n_q, n_d;
    logic [E-1:0]  e_q, e_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  mr_q, mr_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [N-1:0]  o_q, o_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          mm_run_q, mm_run_d;

    mm_op_t        mm_op;
    logic          mm_start;
    logic [N-1:0]  mm_x;
    logic [N-1:0]  mm_y;
    logic [N-1:0]  mm_o;
    logic          mm_done;
    logic          accept;
    logic          last_bit;

    assign accept   = bus.start && ready_q;
    assign last_bit = (cnt_q == CW'(1));

    modmult_seq #(.N(N)) u_mult (
        .clk   (clk),
        .rst   (rst),
        .start (mm_start),
        .x     (mm_x),
        .y     (mm_y),
        .n     (n_q),
        .o     (mm_o),
        .done  (mm_done)
    );

    always_comb begin
        mm_x = acc_q;
        mm_y = acc_q;
        case (mm_op)
            OP_REDUCE:   begin mm_x = m_q;   mm_y = N'(1); end
            OP_SQUARE:   begin mm_x = acc_q; mm_y = acc_q; end
            OP_MULTIPLY: begin mm_x = acc_q; mm_y = mr_q;  end
            default:     begin mm_x = acc_q; mm_y = acc_q; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        n_d      = n_q;
        e_d      = e_q;
        cnt_d    = cnt_q;
        mr_d     = mr_q;
        acc_d    = acc_q;
        o_d      = o_q;
        err_d    = err_q;
        done_d   = 1'b0;
        ready_d  = 1'b0;
        mm_run_d = mm_run_q;
        mm_start = 1'b0;
        mm_op    = OP_REDUCE;

        case (state_q)
            ST_IDLE: begin
                ready_d = !accept;
                if (accept) begin
                    m_d   = bus.m;
                    e_d   = bus.e;
                    n_d   = bus.n;
                    cnt_d = CW'(E);
                    acc_d = '0;
                    o_d   = '0;
                    err_d = 1'b0;
                    state_d = (bus.n == '0) ? ST_FIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                mm_op    = OP_REDUCE;
                mm_start = !mm_run_q;
                mm_run_d = 1'b1;
                if (mm_done) begin
                    mm_run_d = 1'b0;
                    mr_d     = mm_o;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                e_d   = e_q << 1;
                cnt_d = cnt_q - CW'(1);
                if (e_q[E-1]) begin
                    acc_d   = mr_q;
                    state_d = last_bit ? ST_FIN : ST_SQR;
                end else if (last_bit) begin
                    acc_d   = (n_q == N'(1)) ? '0 : N'(1);
                    state_d = ST_FIN;
                end
            end
            ST_SQR: begin
                mm_op    = OP_SQUARE;
                mm_start = !mm_run_q;
                mm_run_d = 1'b1;
                if (mm_done) begin
                    mm_run_d = 1'b0;
                    acc_d    = mm_o;
                    // A set bit is consumed by the following MUL, not here.
                    if (e_q[E-1]) begin
                        state_d = ST_MUL;
                    end else begin
                        e_d     = e_q << 1;
                        cnt_d   = cnt_q - CW'(1);
                        state_d = last_bit ? ST_FIN : ST_SQR;
                    end
                end
            end
            ST_MUL: begin
                mm_op    = OP_MULTIPLY;
                mm_start = !mm_run_q;
                mm_run_d = 1'b1;
                if (mm_done) begin
                    mm_run_d = 1'b0;
                    acc_d    = mm_o;
                    e_d      = e_q << 1;
                    cnt_d    = cnt_q - CW'(1);
                    state_d  = last_bit ? ST_FIN : ST_SQR;
                end
            end
            ST_FIN: begin
                o_d     = acc_q;
                err_d   = (n_q == '0);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered, so done/o/err appear the cycle after FIN and
    // ready stays low through that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            m_q      <= '0;
            n_q      <= '0;
            e_q      <= '0;
            cnt_q    <= '0;
            mr_q     <= '0;
            acc_q    <= '0;
            o_q      <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            mm_run_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            n_q      <= n_d;
            e_q      <= e_d;
            cnt_q    <= cnt_d;
            mr_q     <= mr_d;
            acc_q    <= acc_d;
            o_q      <= o_d;
            err_q    <= err_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            mm_run_q <= mm_run_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.o     = o_q;
endmodule

// File: tb/tb_modexp_seq.sv
// Directed (N=8,E=8) and randomized (N=16,E=16) checks of modexp_seq against
// a right-to-left arithmetic reference and the closed-form latency.
module tb_modexp_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    modexp_seq_if #(.N(8),  .E(8))  b8 ();
    modexp_seq_if #(.N(16), .E(16)) b16 ();

    modexp_seq #(.N(8),  .E(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8));
    modexp_seq #(.N(16), .E(16)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));

    function automatic longint unsigned ref_pow(input longint unsigned m,
                                                input longint unsigned e,
                                                input longint unsigned n);
        longint unsigned res;
        longint unsigned b;
        longint unsigned k;
        if (n == 0) return 0;
        res = 1 % n;
        b   = m % n;
        k   = e;
        while (k != 0) begin
            if (k[0]) res = (res * b) % n;
            b = (b * b) % n;
            k = k >> 1;
        end
        return res;
    endfunction

    function automatic int ref_lat(input int nw, input int ew,
                                   input longint unsigned e, input longint unsigned n);
        int h;
        int ones;
        h = 0;
        ones = 0;
        if (n == 0) return 2;
        if (e == 0) return 1 + (nw + 1) + ew + 1;
        for (int i = 0; i < ew; i++) begin
            if (e[i]) begin
                h = i;
                ones++;
            end
        end
        return 1 + (nw + 1) + (ew - h) + (nw + 1) * (h + ones - 1) + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] m, input logic [7:0] e, input logic [7:0] n,
                       output logic [7:0] o, output logic err, output int lat);
        int guard;
        guard = 0;
        while (!b8.ready && guard < 2000) begin
            step();
            guard++;
        end
        b8.start = 1'b1; b8.m = m; b8.e = e; b8.n = n;
        lat = -1; o = '0; err = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            step();
            if (c == 1) begin
                b8.start = 1'b0;
                b8.m = 8'($urandom); b8.e = 8'($urandom); b8.n = 8'($urandom);
            end
            if (b8.done) begin
                lat = c; o = b8.o; err = b8.err;
                break;
            end
        end
        if (lat < 0) begin
            vectors++; miscompares++;
            $display("FAIL op8_timeout: got no done, want done within 2000 cycles");
        end
        $display("op8  m=%0d e=0x%02h n=%0d -> o=%0d err=%0d lat=%0d", m, e, n, o, err, lat);
    endtask

    task automatic op16(input logic [15:0] m, input logic [15:0] e, input logic [15:0] n,
                        output logic [15:0] o, output logic err, output int lat);
        int guard;
        guard = 0;
        while (!b16.ready && guard < 2000) begin
            step();
            guard++;
        end
        b16.start = 1'b1; b16.m = m; b16.e = e; b16.n = n;
        lat = -1; o = '0; err = 1'b0;
        for (int c = 1; c <= 2000; c++) begin
            step();
            if (c == 1) begin
                b16.start = 1'b0;
                b16.m = 16'($urandom); b16.e = 16'($urandom); b16.n = 16'($urandom);
            end
            if (b16.done) begin
                lat = c; o = b16.o; err = b16.err;
                break;
            end
        end
        if (lat < 0) begin
            vectors++; miscompares++;
            $display("FAIL op16_timeout: got no done, want done within 2000 cycles");
        end
        $display("op16 m=%0d e=0x%04h n=%0d -> o=%0d err=%0d lat=%0d", m, e, n, o, err, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b8.start = 1'b0;  b8.m = '0;  b8.e = '0;  b8.n = '0;
        b16.start = 1'b0; b16.m = '0; b16.e = '0; b16.n = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        vectors++; if (b8.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", b8.ready); end
        vectors++; if (b8.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", b8.done); end
        vectors++; if (b8.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", b8.err); end
        vectors++; if (b8.o !== 8'd0) begin miscompares++; $display("FAIL reset_o: got %0d want 0", b8.o); end
        vectors++; if (b16.ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready16: got %b want 1", b16.ready); end
    endtask

    // Each entry: m, e, n; o and latency come from the reference model.
    task automatic test_directed();
        logic [7:0] tm [6] = '{8'd5, 8'd200, 8'd2,   8'd9,  8'd7,  8'd123};
        logic [7:0] te [6] = '{8'h03, 8'h01, 8'hFF, 8'h00, 8'h00, 8'hA5};
        logic [7:0] tn [6] = '{8'd13, 8'd13, 8'd251, 8'd13, 8'd1,  8'd255};
        logic [7:0] o;
        logic err;
        int lat;
        logic [7:0] exp_o;
        int exp_l;
        for (int i = 0; i < 6; i++) begin
            op8(tm[i], te[i], tn[i], o, err, lat);
            exp_o = 8'(ref_pow(64'(tm[i]), 64'(te[i]), 64'(tn[i])));
            exp_l = ref_lat(8, 8, 64'(te[i]), 64'(tn[i]));
            vectors++; if (o !== exp_o) begin miscompares++; $display("FAIL directed_o[%0d]: got %0d want %0d", i, o, exp_o); end
            vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL directed_err[%0d]: got %b want 0", i, err); end
            vectors++; if (lat != exp_l) begin miscompares++; $display("FAIL directed_lat[%0d]: got %0d want %0d", i, lat, exp_l); end
        end
    endtask

    task automatic test_basic_latency();
        logic [7:0] o;
        logic err;
        int lat;
        op8(8'd5, 8'h03, 8'd13, o, err, lat);
        vectors++; if (lat != 36) begin miscompares++; $display("FAIL basic_lat: got %0d want 36", lat); end
        vectors++; if (o !== 8'd8) begin miscompares++; $display("FAIL basic_o: got %0d want 8", o); end
    endtask

    task automatic test_n_zero();
        logic [7:0] o;
        logic err;
        int lat;
        int c;
        op8(8'd77, 8'h05, 8'd0, o, err, lat);
        vectors++; if (lat != 2) begin miscompares++; $display("FAIL nzero_lat: got %0d want 2", lat); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL nzero_err: got %b want 1", err); end
        vectors++; if (o !== 8'd0) begin miscompares++; $display("FAIL nzero_o: got %0d want 0", o); end
        step();
        b8.start = 1'b1; b8.m = 8'd3; b8.e = 8'h02; b8.n = 8'd7;
        step();
        b8.start = 1'b0;
        vectors++; if (b8.err !== 1'b0) begin miscompares++; $display("FAIL nzero_err_clear: got %b want 0", b8.err); end
        c = 1;
        while (!b8.done && c < 500) begin
            step();
            c++;
        end
        vectors++; if (!b8.done || b8.o !== 8'd2 || b8.err !== 1'b0) begin
            miscompares++; $display("FAIL nzero_next: got done=%b o=%0d err=%b want done=1 o=2 err=0", b8.done, b8.o, b8.err);
        end
        vectors++; if (c != ref_lat(8, 8, 64'h2, 64'd7)) begin
            miscompares++; $display("FAIL nzero_next_lat: got %0d want %0d", c, ref_lat(8, 8, 64'h2, 64'd7));
        end
        $display("op8  m=3 e=0x02 n=7 -> o=%0d err=%0d lat=%0d", b8.o, b8.err, c);
    endtask

    task automatic test_ignore_start();
        int lat;
        int extra;
        logic [7:0] o;
        step();
        b8.start = 1'b1; b8.m = 8'd5; b8.e = 8'h03; b8.n = 8'd13;
        lat = -1; o = '0;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (c == 1)  b8.start = 1'b0;
            if (c == 10) begin b8.start = 1'b1; b8.m = 8'd7; b8.e = 8'h55; b8.n = 8'd11; end
            if (c == 11) b8.start = 1'b0;
            if (b8.done) begin lat = c; o = b8.o; break; end
        end
        vectors++; if (lat != 36 || o !== 8'd8) begin
            miscompares++; $display("FAIL ignore_result: got lat=%0d o=%0d want lat=36 o=8", lat, o);
        end
        extra = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (b8.done) extra++;
        end
        vectors++; if (extra != 0 || b8.ready !== 1'b1) begin
            miscompares++; $display("FAIL ignore_no_queue: got extra_done=%0d ready=%b want 0 and 1", extra, b8.ready);
        end
        $display("op8  ignored mid-op start -> o=%0d lat=%0d", o, lat);
    endtask

    task automatic test_rst_mid_sqr();
        logic [7:0] o;
        logic err;
        int lat;
        b8.start = 1'b1; b8.m = 8'd2; b8.e = 8'hFF; b8.n = 8'd251;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c == 1) b8.start = 1'b0;
        end
        vectors++; if (b8.ready !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got ready=%b want 0", b8.ready); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (b8.ready !== 1'b1 || b8.o !== 8'd0 || b8.done !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid: got ready=%b o=%0d done=%b want 1 0 0", b8.ready, b8.o, b8.done);
        end
        op8(8'd5, 8'h03, 8'd13, o, err, lat);
        vectors++; if (o !== 8'd8 || lat != 36) begin
            miscompares++; $display("FAIL rst_fresh: got o=%0d lat=%0d want 8 36", o, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] o;
        logic err;
        int lat;
        op8(8'd9, 8'h0B, 8'd17, o, err, lat);
        vectors++; if (b8.ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_done: got %b want 0", b8.ready); end
        step();
        vectors++; if (b8.ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_next: got %b want 1", b8.ready); end
        op8(8'd4, 8'h80, 8'd9, o, err, lat);
        vectors++; if (o !== 8'(ref_pow(64'd4, 64'h80, 64'd9)) || lat != ref_lat(8, 8, 64'h80, 64'd9)) begin
            miscompares++; $display("FAIL b2b_second: got o=%0d lat=%0d want %0d %0d", o,
                                    lat, ref_pow(64'd4, 64'h80, 64'd9), ref_lat(8, 8, 64'h80, 64'd9));
        end
    endtask

    task automatic test_random();
        logic [15:0] m;
        logic [15:0] e;
        logic [15:0] n;
        logic [15:0] o;
        logic [15:0] exp_o;
        logic err;
        int lat;
        int exp_l;
        for (int i = 0; i < 200; i++) begin
            m = 16'($urandom);
            e = 16'($urandom) >> $urandom_range(0, 16);
            n = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
            op16(m, e, n, o, err, lat);
            exp_o = 16'(ref_pow(64'(m), 64'(e), 64'(n)));
            exp_l = ref_lat(16, 16, 64'(e), 64'(n));
            vectors++; if (o !== exp_o || err !== (n == 16'd0) || lat != exp_l) begin
                miscompares++;
                $display("FAIL random[%0d]: got o=%0d err=%b lat=%0d want o=%0d err=%b lat=%0d",
                         i, o, err, lat, exp_o, (n == 16'd0), exp_l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_directed();
        test_n_zero();
        test_ignore_start();
        test_rst_mid_sqr();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
